// File: rtl/btn_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : btn_tx_arbiter
// Purpose  : Shares one UART transmitter between four button-pulse requesters.
//            Each pulse queues a one-byte code; a round-robin arbiter hands the
//            queued codes to the UART TX one at a time using a start/done
//            handshake, with timeout recovery if done never arrives.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            i_btn[3:0]        - one-cycle request pulses, bit n = button n
//            i_tx_busy         - UART TX busy (blocks new grants)
//            i_tx_done         - one-cycle pulse, byte fully transmitted
//            o_tx_start        - one-cycle start strobe to UART TX
//            o_tx_data[7:0]    - byte to send, held until the next grant
//            o_pending[3:0]    - queued-request flags
//            o_busy            - high while a grant is in progress
//            o_drop            - pulse: request hit an already-pending button
//            o_timeout         - pulse: done not seen within TX_TIMEOUT cycles
// Revision : 1.0 - initial release
// ============================================================================
module btn_tx_arbiter #(
  parameter logic [7:0] CODE_0     = 8'h55,
  parameter logic [7:0] CODE_1     = 8'h44,
  parameter logic [7:0] CODE_2     = 8'h4C,
  parameter logic [7:0] CODE_3     = 8'h52,
  parameter int         TX_TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_btn,
  input  logic       i_tx_busy,
  input  logic       i_tx_done,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic [3:0] o_pending,
  output logic       o_busy,
  output logic       o_drop,
  output logic       o_timeout
);

  localparam int            c_TW   = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_pending;
  logic [1:0]      r_rr_ptr;
  logic [1:0]      r_win;
  logic [c_TW-1:0] r_timer;

  logic [1:0]      w_winner;
  logic [7:0]      w_code;
  logic [3:0]      w_clr;

  // Round-robin pick: scan from the highest offset down so the entry closest
  // to r_rr_ptr is the last (and therefore winning) assignment.
  always_comb begin
    w_winner = r_rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[r_rr_ptr + 2'(i)]) begin
        w_winner = r_rr_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    case (w_winner)
      2'd0:    w_code = CODE_0;
      2'd1:    w_code = CODE_1;
      2'd2:    w_code = CODE_2;
      default: w_code = CODE_3;
    endcase
  end

  // The granted bit is cleared while in START; a fresh press in that same
  // cycle re-sets it below because the OR with i_btn is applied last.
  assign w_clr = (r_state == ST_START) ? (4'b0001 << r_win) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pending  <= 4'b0000;
      r_rr_ptr   <= 2'd0;
      r_win      <= 2'd0;
      r_timer    <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= 8'h00;
      o_busy     <= 1'b0;
      o_drop     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      r_pending  <= (r_pending & ~w_clr) | i_btn;
      o_drop     <= |(i_btn & r_pending & ~w_clr);
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if ((r_pending != 4'b0000) && !i_tx_busy) begin
            r_state    <= ST_START;
            r_win      <= w_winner;
            o_tx_data  <= w_code;
            o_tx_start <= 1'b1;
            o_busy     <= 1'b1;
          end
        end

        ST_START: begin
          r_rr_ptr <= r_win + 2'd1;
          r_timer  <= '0;
          r_state  <= ST_WAIT;
        end

        ST_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // done takes priority over a coincident timeout
          if (i_tx_done) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end else if (r_timer == c_TMAX) begin
            r_state   <= ST_IDLE;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pending = r_pending;

endmodule
`default_nettype wire
